// File: rtl/fb_access_arbiter_if.sv
// Custom-instruction handshake between the NIOS core and the frame-buffer
// arbiter: a start/done pair with two operand words and one status word.
`timescale 1ns/1ps

interface fb_access_arbiter_if;
   logic        start;
   logic [31:0] dataa;
   logic [31:0] datab;
   logic        done;
   logic [31:0] result;

   // NIOS side: issues commands and waits for completion
   modport master (
      output start,
      output dataa,
      output datab,
      input  done,
      input  result
   );

   // Arbiter side: accepts commands and reports status
   modport slave (
      input  start,
      input  dataa,
      input  datab,
      output done,
      output result
   );
endinterface

// File: rtl/fb_access_arbiter.sv
// Frame-buffer access arbiter: shares one 4096x1 RAM between the fixed-timing
// VGA scan-out reader (always wins) and the NIOS custom-instruction writer,
// which drops 32 pixel bits into the buffer only while the scan is outside
// the image window.
`timescale 1ns/1ps

module fb_access_arbiter #(
   parameter int ADDR_W = 12,
   parameter int WORD_W = 32,
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64
) (
   input  logic              clk,
   input  logic              reset,
   fb_access_arbiter_if.slave ci,
   input  logic [9:0]        counter_x,
   input  logic [9:0]        counter_y,
   input  logic              in_display_area,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_data,
   output logic              ram_wren,
   input  logic              ram_q,
   output logic              pixel_bit,
   output logic              pixel_valid
);

   localparam int XW    = $clog2(IMG_W);
   localparam int YW    = $clog2(IMG_H);
   localparam int IDX_W = $clog2(WORD_W);

   localparam logic [9:0]        IMG_W_C  = 10'(IMG_W);
   localparam logic [9:0]        IMG_H_C  = 10'(IMG_H);
   localparam logic [ADDR_W-1:0] MAX_BASE = ADDR_W'(IMG_W * IMG_H - WORD_W);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_W - 1);
   localparam logic [7:0]        BITS_ALL = 8'(WORD_W);

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      WRITE,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic              start_q;
   logic [ADDR_W-1:0] base;
   logic              hi_err;
   logic [WORD_W-1:0] data;
   logic [IDX_W-1:0]  idx;
   logic [15:0]       stall;
   logic              win_q;

   logic              win;
   logic              accept;
   logic              range_bad;
   logic              write_now;
   logic [ADDR_W-1:0] scan_addr;

   // The scan address is rebuilt from the counters every cycle, so it can
   // never drift from the raster even after a reset in mid-frame.
   assign win       = in_display_area && (counter_x < IMG_W_C) && (counter_y < IMG_H_C);
   assign scan_addr = ADDR_W'({counter_y[YW-1:0], counter_x[XW-1:0]});
   assign accept    = ci.start && !start_q && (state == IDLE);
   assign range_bad = hi_err || (base > MAX_BASE);
   assign write_now = (state == WRITE) && !win;

   // State register; reset abandons any write in progress without a done pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and the RAM port mux; the scan read always wins the port
   always_comb begin
      state_next = state;
      ram_addr   = scan_addr;
      ram_data   = 1'b0;
      ram_wren   = 1'b0;
      ci.done    = (state == DONE);

      if (write_now) begin
         ram_addr = base + ADDR_W'(idx);
         ram_data = data[idx];
         ram_wren = 1'b1;
      end

      case (state)
         IDLE: begin
            if (accept) begin
               state_next = CHECK;
            end
         end
         CHECK: begin
            state_next = range_bad ? DONE : WRITE;
         end
         WRITE: begin
            if (write_now && (idx == IDX_LAST)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Command capture, bit index and stall counting for the write sequence
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_q <= 1'b0;
         base    <= '0;
         hi_err  <= 1'b0;
         data    <= '0;
         idx     <= '0;
         stall   <= '0;
      end else begin
         start_q <= ci.start;
         case (state)
            IDLE: begin
               if (accept) begin
                  base   <= ci.dataa[ADDR_W-1:0];
                  hi_err <= |ci.dataa[31:ADDR_W];
                  data   <= ci.datab;
                  idx    <= '0;
                  stall  <= '0;
               end
            end
            WRITE: begin
               if (win) begin
                  if (stall != 16'hFFFF) begin
                     stall <= stall + 16'd1;
                  end
               end else if (idx != IDX_LAST) begin
                  idx <= idx + IDX_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status word is captured on the way into DONE and then held; range_bad is
   // only ever true when arriving from CHECK, so it doubles as the error flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ci.result <= '0;
      end else if ((state_next == DONE) && (state != DONE)) begin
         ci.result <= {stall, (range_bad ? 8'h00 : BITS_ALL), 7'b0, range_bad};
      end
   end

   // Scan-out pipeline: RAM read takes one cycle, the output register a second
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_q       <= 1'b0;
         pixel_valid <= 1'b0;
         pixel_bit   <= 1'b0;
      end else begin
         win_q       <= win;
         pixel_valid <= win_q;
         pixel_bit   <= ram_q;
      end
   end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Self-checking bench for fb_access_arbiter: a behavioural RAM, a monitor that
// logs every RAM write and done pulse, and per-scenario tasks that compare the
// logged traffic against expected records queued when each command is issued.
`timescale 1ns/1ps

module tb_fb_access_arbiter;

   typedef struct {
      logic [11:0] addr;
      logic        data;
      int          cyc;
   } wr_t;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } dn_t;

   typedef struct {
      logic valid;
      logic pix;
   } px_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [9:0]  counter_x = 10'd100;
   logic [9:0]  counter_y = 10'd100;
   logic        in_display_area = 1'b1;
   logic [11:0] ram_addr;
   logic        ram_data;
   logic        ram_wren;
   logic        ram_q = 1'b0;
   logic        pixel_bit;
   logic        pixel_valid;
   logic        tb_win;

   logic        mem     [0:4095];
   logic        ref_img [0:4095];

   int cyc = 0;
   int total = 0;
   int bad = 0;
   int wr_in_win = 0;
   int scan_bad = 0;

   wr_t exp_wr[$];
   wr_t obs_wr[$];
   dn_t exp_done[$];
   dn_t obs_done[$];
   wr_t mw;
   dn_t md;

   fb_access_arbiter_if ci();

   fb_access_arbiter #(
      .ADDR_W(12),
      .WORD_W(32),
      .IMG_W(64),
      .IMG_H(64)
   ) dut (
      .clk(clk),
      .reset(reset),
      .ci(ci),
      .counter_x(counter_x),
      .counter_y(counter_y),
      .in_display_area(in_display_area),
      .ram_addr(ram_addr),
      .ram_data(ram_data),
      .ram_wren(ram_wren),
      .ram_q(ram_q),
      .pixel_bit(pixel_bit),
      .pixel_valid(pixel_valid)
   );

   // 25 MHz pixel clock
   always #20 clk = ~clk;

   // Period number, advanced at every rising edge
   always @(posedge clk) cyc <= cyc + 1;

   // Registered-address single-port RAM
   always @(posedge clk) begin
      if (ram_wren === 1'b1) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   assign tb_win = in_display_area && (counter_x < 10'd64) && (counter_y < 10'd64);

   // Log write and done traffic mid-cycle for the scenario tasks to judge
   always @(negedge clk) begin
      if (ram_wren === 1'b1) begin
         mw.addr = ram_addr;
         mw.data = ram_data;
         mw.cyc  = cyc;
         obs_wr.push_back(mw);
         if (tb_win) wr_in_win++;
      end
      if (ci.done === 1'b1) begin
         md.res = ci.result;
         md.cyc = cyc;
         obs_done.push_back(md);
      end
      if (tb_win && (ram_addr !== {counter_y[5:0], counter_x[5:0]})) scan_bad++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue the expected writes and done record for a command started in period p0
   task automatic push_expected(input logic [31:0] a, input logic [31:0] b,
                                input int p0, input int lo, input int hi);
      int rel;
      int stalls;
      wr_t w;
      dn_t d;
      if (a > 32'd4064) begin
         d.res = 32'h0000_0001;
         d.cyc = p0 + 2;
         exp_done.push_back(d);
         return;
      end
      rel = 2;
      stalls = 0;
      for (int i = 0; i < 32; i++) begin
         while (rel >= lo && rel <= hi) begin
            rel++;
            stalls++;
         end
         w.addr = a[11:0] + 12'(i);
         w.data = b[i];
         w.cyc  = p0 + rel;
         exp_wr.push_back(w);
         ref_img[w.addr] = b[i];
         rel++;
      end
      d.res = (32'(stalls) << 16) | 32'h0000_2000;
      d.cyc = p0 + rel;
      exp_done.push_back(d);
   endtask

   // Issue one command; window forced during rel periods lo..hi, optional second start edge
   task automatic run_command(input logic [31:0] a, input logic [31:0] b, input int hold,
                              input int lo, input int hi, input int repulse, input int budget);
      int p0;
      int r;
      tick();
      ci.dataa = a;
      ci.datab = b;
      ci.start = 1'b1;
      p0 = cyc;
      for (int k = 1; k <= budget; k++) begin
         tick();
         r = cyc - p0;
         ci.start = (r < hold) || (r == repulse);
         if (r == repulse) begin
            ci.dataa = 32'd0;
            ci.datab = 32'hFFFF_FFFF;
         end
         if (r >= lo && r <= hi) begin
            counter_x = 10'(r);
            counter_y = 10'd3;
         end else begin
            counter_x = 10'd100;
            counter_y = 10'd100;
         end
         in_display_area = 1'b1;
      end
      ci.start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      ci.start = 1'b0;
      ci.dataa = 32'd0;
      ci.datab = 32'd0;
      counter_x = 10'd5;
      counter_y = 10'd5;
      in_display_area = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      total++;
      if (ram_wren !== 1'b0) begin bad++; $display("[TB] FAIL rst_wren: got %b want 0", ram_wren); end
      total++;
      if (ci.done !== 1'b0) begin bad++; $display("[TB] FAIL rst_done: got %b want 0", ci.done); end
      total++;
      if (ci.result !== 32'd0) begin bad++; $display("[TB] FAIL rst_result: got %h want 0", ci.result); end
      total++;
      if (pixel_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_pixel_valid: got %b want 0", pixel_valid); end
      total++;
      if (pixel_bit !== 1'b0) begin bad++; $display("[TB] FAIL rst_pixel_bit: got %b want 0", pixel_bit); end
      counter_x = 10'd100;
      counter_y = 10'd100;
      tick();
      reset = 1'b1;
      repeat (3) tick();
      obs_wr.delete();
      obs_done.delete();
   endtask

   task automatic test_blanking_write();
      wr_t e, o;
      dn_t ed, od;
      push_expected(32'd0, 32'hA5A5_A5A5, cyc + 1, 0, -1);
      run_command(32'd0, 32'hA5A5_A5A5, 1, 0, -1, -1, 40);
      total++;
      if (obs_wr.size() != exp_wr.size()) begin
         bad++; $display("[TB] FAIL blank_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
      end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e = exp_wr.pop_front(); o = obs_wr.pop_front(); total++;
         if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
            bad++; $display("[TB] FAIL blank_wr: got a=%0d d=%b c=%0d want a=%0d d=%b c=%0d",
                            o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
         end
      end
      total++;
      if (obs_done.size() != 1 || exp_done.size() != 1) begin
         bad++; $display("[TB] FAIL blank_done_count: got %0d want 1", obs_done.size());
      end else begin
         ed = exp_done.pop_front(); od = obs_done.pop_front(); total++;
         if (od.res !== ed.res || od.cyc !== ed.cyc) begin
            bad++; $display("[TB] FAIL blank_done: got r=%h c=%0d want r=%h c=%0d", od.res, od.cyc, ed.res, ed.cyc);
         end
      end
      exp_wr.delete(); obs_wr.delete(); exp_done.delete(); obs_done.delete();
   endtask

   task automatic test_contention();
      wr_t e, o;
      dn_t ed, od;
      wr_in_win = 0;
      scan_bad = 0;
      push_expected(32'd128, 32'h3C5A_F00F, cyc + 1, 6, 15);
      run_command(32'd128, 32'h3C5A_F00F, 1, 6, 15, -1, 50);
      total++;
      if (obs_wr.size() != exp_wr.size()) begin
         bad++; $display("[TB] FAIL cont_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
      end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e = exp_wr.pop_front(); o = obs_wr.pop_front(); total++;
         if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
            bad++; $display("[TB] FAIL cont_wr: got a=%0d d=%b c=%0d want a=%0d d=%b c=%0d",
                            o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
         end
      end
      total++;
      if (obs_done.size() != 1 || exp_done.size() != 1) begin
         bad++; $display("[TB] FAIL cont_done_count: got %0d want 1", obs_done.size());
      end else begin
         ed = exp_done.pop_front(); od = obs_done.pop_front(); total++;
         if (od.res !== ed.res || od.cyc !== ed.cyc) begin
            bad++; $display("[TB] FAIL cont_done: got r=%h c=%0d want r=%h c=%0d", od.res, od.cyc, ed.res, ed.cyc);
         end
      end
      total++;
      if (wr_in_win != 0) begin bad++; $display("[TB] FAIL cont_wren_in_win: got %0d want 0", wr_in_win); end
      total++;
      if (scan_bad != 0) begin bad++; $display("[TB] FAIL cont_scan_addr: got %0d bad cycles want 0", scan_bad); end
      exp_wr.delete(); obs_wr.delete(); exp_done.delete(); obs_done.delete();
   endtask

   task automatic test_range_error();
      logic [31:0] addrs [2];
      dn_t ed, od;
      addrs[0] = 32'd4065;
      addrs[1] = 32'h0000_1000;
      for (int t = 0; t < 2; t++) begin
         push_expected(addrs[t], 32'hFFFF_FFFF, cyc + 1, 0, -1);
         run_command(addrs[t], 32'hFFFF_FFFF, 1, 0, -1, -1, 6);
         total++;
         if (obs_wr.size() != 0) begin
            bad++; $display("[TB] FAIL range_no_write: got %0d writes want 0 (dataa=%h)", obs_wr.size(), addrs[t]);
         end
         total++;
         if (obs_done.size() != 1 || exp_done.size() != 1) begin
            bad++; $display("[TB] FAIL range_done_count: got %0d want 1", obs_done.size());
         end else begin
            ed = exp_done.pop_front(); od = obs_done.pop_front(); total++;
            if (od.res !== ed.res || od.cyc !== ed.cyc) begin
               bad++; $display("[TB] FAIL range_done: got r=%h c=%0d want r=%h c=%0d", od.res, od.cyc, ed.res, ed.cyc);
            end
         end
         exp_wr.delete(); obs_wr.delete(); exp_done.delete(); obs_done.delete();
      end
   endtask

   task automatic test_boundary_readback();
      wr_t e, o;
      dn_t ed, od;
      int qx[$];
      int qy[$];
      px_t pq[$];
      px_t p, pe;
      int n;
      push_expected(32'd4064, 32'hFFFF_FFFF, cyc + 1, 0, -1);
      run_command(32'd4064, 32'hFFFF_FFFF, 1, 0, -1, -1, 40);
      total++;
      if (obs_wr.size() != exp_wr.size()) begin
         bad++; $display("[TB] FAIL bound_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
      end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e = exp_wr.pop_front(); o = obs_wr.pop_front(); total++;
         if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
            bad++; $display("[TB] FAIL bound_wr: got a=%0d d=%b c=%0d want a=%0d d=%b c=%0d",
                            o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
         end
      end
      total++;
      if (obs_done.size() != 1 || exp_done.size() != 1) begin
         bad++; $display("[TB] FAIL bound_done_count: got %0d want 1", obs_done.size());
      end else begin
         ed = exp_done.pop_front(); od = obs_done.pop_front(); total++;
         if (od.res !== ed.res || od.cyc !== ed.cyc) begin
            bad++; $display("[TB] FAIL bound_done: got r=%h c=%0d want r=%h c=%0d", od.res, od.cyc, ed.res, ed.cyc);
         end
      end
      exp_wr.delete(); obs_wr.delete(); exp_done.delete(); obs_done.delete();

      for (int x = 0; x <= 40; x++) begin qx.push_back(x); qy.push_back(0); end
      for (int x = 28; x <= 65; x++) begin qx.push_back(x); qy.push_back(63); end
      n = qx.size();
      for (int j = 0; j < n + 2; j++) begin
         tick();
         if (j < n) begin
            counter_x = 10'(qx[j]);
            counter_y = 10'(qy[j]);
            in_display_area = 1'b1;
            p.valid = (qx[j] < 64) && (qy[j] < 64);
            p.pix = ref_img[(qy[j] % 64) * 64 + (qx[j] % 64)];
            pq.push_back(p);
         end else begin
            counter_x = 10'd100;
            counter_y = 10'd100;
         end
         @(negedge clk);
         if (j >= 2) begin
            pe = pq.pop_front();
            total++;
            if (pixel_valid !== pe.valid) begin
               bad++; $display("[TB] FAIL scan_valid[%0d]: got %b want %b", j - 2, pixel_valid, pe.valid);
            end else if (pe.valid && pixel_bit !== pe.pix) begin
               bad++; $display("[TB] FAIL scan_pixel[%0d]: got %b want %b", j - 2, pixel_bit, pe.pix);
            end
         end
      end
      obs_wr.delete(); obs_done.delete();
   endtask

   task automatic test_handshake();
      wr_t e, o;
      dn_t ed, od;
      for (int t = 0; t < 2; t++) begin
         if (t == 0) begin
            push_expected(32'd256, 32'h1234_5678, cyc + 1, 0, -1);
            run_command(32'd256, 32'h1234_5678, 100, 0, -1, -1, 105);
         end else begin
            push_expected(32'd320, 32'h0F0F_0F0F, cyc + 1, 0, -1);
            run_command(32'd320, 32'h0F0F_0F0F, 1, 0, -1, 10, 45);
         end
         total++;
         if (obs_wr.size() != exp_wr.size()) begin
            bad++; $display("[TB] FAIL hs%0d_wr_count: got %0d want %0d", t, obs_wr.size(), exp_wr.size());
         end
         while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front(); o = obs_wr.pop_front(); total++;
            if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
               bad++; $display("[TB] FAIL hs%0d_wr: got a=%0d d=%b c=%0d want a=%0d d=%b c=%0d",
                               t, o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
            end
         end
         total++;
         if (obs_done.size() != 1 || exp_done.size() != 1) begin
            bad++; $display("[TB] FAIL hs%0d_done_count: got %0d want 1", t, obs_done.size());
         end else begin
            ed = exp_done.pop_front(); od = obs_done.pop_front(); total++;
            if (od.res !== ed.res || od.cyc !== ed.cyc) begin
               bad++; $display("[TB] FAIL hs%0d_done: got r=%h c=%0d want r=%h c=%0d", t, od.res, od.cyc, ed.res, ed.cyc);
            end
         end
         exp_wr.delete(); obs_wr.delete(); exp_done.delete(); obs_done.delete();
      end
   endtask

   task automatic test_reset_mid_write();
      wr_t e, o;
      dn_t ed, od;
      int p0;
      logic [31:0] b;
      b = 32'hDEAD_BEEF;
      p0 = cyc + 1;
      for (int i = 0; i < 10; i++) begin
         e.addr = 12'd512 + 12'(i);
         e.data = b[i];
         e.cyc  = p0 + 2 + i;
         exp_wr.push_back(e);
         ref_img[e.addr] = b[i];
      end
      tick();
      ci.dataa = 32'd512;
      ci.datab = b;
      ci.start = 1'b1;
      for (int r = 1; r < 12; r++) begin
         tick();
         ci.start = 1'b0;
      end
      tick();
      reset = 1'b0;
      #1;
      total++;
      if (ram_wren !== 1'b0) begin bad++; $display("[TB] FAIL midrst_wren: got %b want 0", ram_wren); end
      @(negedge clk);
      total++;
      if (ci.result !== 32'd0) begin bad++; $display("[TB] FAIL midrst_result: got %h want 0", ci.result); end
      repeat (2) tick();
      reset = 1'b1;
      repeat (40) tick();
      total++;
      if (obs_wr.size() != exp_wr.size()) begin
         bad++; $display("[TB] FAIL midrst_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
      end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e = exp_wr.pop_front(); o = obs_wr.pop_front(); total++;
         if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
            bad++; $display("[TB] FAIL midrst_wr: got a=%0d d=%b c=%0d want a=%0d d=%b c=%0d",
                            o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
         end
      end
      total++;
      if (obs_done.size() != 0) begin bad++; $display("[TB] FAIL midrst_no_done: got %0d want 0", obs_done.size()); end
      exp_wr.delete(); obs_wr.delete(); exp_done.delete(); obs_done.delete();

      push_expected(32'd512, 32'h5555_AAAA, cyc + 1, 0, -1);
      run_command(32'd512, 32'h5555_AAAA, 1, 0, -1, -1, 40);
      total++;
      if (obs_wr.size() != exp_wr.size()) begin
         bad++; $display("[TB] FAIL after_rst_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
      end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e = exp_wr.pop_front(); o = obs_wr.pop_front(); total++;
         if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
            bad++; $display("[TB] FAIL after_rst_wr: got a=%0d d=%b c=%0d want a=%0d d=%b c=%0d",
                            o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
         end
      end
      total++;
      if (obs_done.size() != 1 || exp_done.size() != 1) begin
         bad++; $display("[TB] FAIL after_rst_done_count: got %0d want 1", obs_done.size());
      end else begin
         ed = exp_done.pop_front(); od = obs_done.pop_front(); total++;
         if (od.res !== ed.res || od.cyc !== ed.cyc) begin
            bad++; $display("[TB] FAIL after_rst_done: got r=%h c=%0d want r=%h c=%0d", od.res, od.cyc, ed.res, ed.cyc);
         end
      end
      exp_wr.delete(); obs_wr.delete(); exp_done.delete(); obs_done.delete();
   endtask

   // Scenario sequence
   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem[i] = 1'b0;
         ref_img[i] = 1'b0;
      end
      ci.start = 1'b0;
      ci.dataa = 32'd0;
      ci.datab = 32'd0;
      test_reset();
      test_blanking_write();
      test_contention();
      test_range_error();
      test_boundary_readback();
      test_handshake();
      test_reset_mid_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
